// File: rtl/pretu_stream.sv
// Streaming 4x4 PreTu input transform Y = Bt*X*B: rows are transformed on entry,
// columns on exit, with two ping-pong tile banks for one row per cycle sustained.
module pretu_stream #(
   parameter int unsigned DW = 16,
   parameter int unsigned CW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 mode_bypass,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*DW-1:0]      in_row,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*(DW+2)-1:0]  out_row,
   output logic [1:0]           out_row_idx,
   output logic                 out_last,
   output logic [CW-1:0]        tile_cnt
);

   localparam int unsigned RW = DW + 1;
   localparam int unsigned OW = DW + 2;

   logic [4*RW-1:0] mem_q [2][4];
   logic [1:0]      full_q, full_d;
   logic [1:0]      byp_q, byp_d;
   logic            wr_bank_q, wr_bank_d;
   logic            rd_bank_q, rd_bank_d;
   logic [1:0]      wr_cnt_q, wr_cnt_d;
   logic [1:0]      rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]   tile_cnt_q, tile_cnt_d;

   logic            in_fire, out_fire, byp_in;
   logic [RW-1:0]   xe [4];
   logic [4*RW-1:0] row_d;
   logic [OW-1:0]   re [4][4];
   logic [OW-1:0]   col;

   // Ingress: row operator on the sign-extended inputs; the bank's flag governs rows 1..3
   always_comb begin
      in_ready = !full_q[wr_bank_q] && !flush;
      in_fire  = in_valid && in_ready;
      byp_in   = (wr_cnt_q == 2'd0) ? mode_bypass : byp_q[wr_bank_q];
      for (int j = 0; j < 4; j++) begin
         xe[j] = {in_row[j*DW+DW-1], in_row[j*DW +: DW]};
      end
      row_d = '0;
      if (byp_in) begin
         row_d = {xe[3], xe[2], xe[1], xe[0]};
      end else begin
         row_d = {xe[1] - xe[3], xe[2] - xe[1], xe[1] + xe[2], xe[0] - xe[2]};
      end
   end

   // Egress: column operator straight from the full bank, zeroed when idle
   always_comb begin
      out_valid   = full_q[rd_bank_q];
      out_fire    = out_valid && out_ready;
      out_row     = '0;
      out_row_idx = 2'd0;
      out_last    = 1'b0;
      col         = '0;
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j < 4; j++) begin
            re[r][j] = {mem_q[rd_bank_q][r][j*RW+RW-1], mem_q[rd_bank_q][r][j*RW +: RW]};
         end
      end
      if (out_valid) begin
         out_row_idx = rd_cnt_q;
         out_last    = (rd_cnt_q == 2'd3);
         for (int j = 0; j < 4; j++) begin
            if (byp_q[rd_bank_q]) begin
               col = re[rd_cnt_q][j];
            end else begin
               case (rd_cnt_q)
                  2'd0:    col = re[0][j] - re[2][j];
                  2'd1:    col = re[1][j] + re[2][j];
                  2'd2:    col = re[2][j] - re[1][j];
                  default: col = re[1][j] - re[3][j];
               endcase
            end
            out_row[j*OW +: OW] = col;
         end
      end
   end

   // Bank bookkeeping; writes only hit an empty bank and reads only a full one
   always_comb begin
      full_d     = full_q;
      byp_d      = byp_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      tile_cnt_d = tile_cnt_q;
      if (flush) begin
         wr_cnt_d = 2'd0;
      end else if (in_fire) begin
         wr_cnt_d = wr_cnt_q + 2'd1;
         if (wr_cnt_q == 2'd0) begin
            byp_d[wr_bank_q] = mode_bypass;
         end
         if (wr_cnt_q == 2'd3) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end
      if (out_fire) begin
         rd_cnt_d = rd_cnt_q + 2'd1;
         if (rd_cnt_q == 2'd3) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            tile_cnt_d        = tile_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q     <= 2'b00;
         byp_q      <= 2'b00;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_cnt_q   <= 2'd0;
         rd_cnt_q   <= 2'd0;
         tile_cnt_q <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 4; r++) begin
               mem_q[b][r] <= '0;
            end
         end
      end else begin
         full_q     <= full_d;
         byp_q      <= byp_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         tile_cnt_q <= tile_cnt_d;
         if (in_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= row_d;
         end
      end
   end

   assign tile_cnt = tile_cnt_q;

endmodule

// File: tb/tb_pretu_stream.sv
// Self-checking bench for pretu_stream against a matrix-product model Y = M*X*M^T.
module tb_pretu_stream;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 16;
   localparam int unsigned OW = DW + 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              mode_bypass = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [4*DW-1:0]   in_row = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [4*OW-1:0]   out_row;
   logic [1:0]        out_row_idx;
   logic              out_last;
   logic [CW-1:0]     tile_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int tiles_total = 0;
   int tx [100][16];
   bit tbyp [100];
   int mm [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};

   pretu_stream #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .mode_bypass(mode_bypass),
      .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_row_idx(out_row_idx), .out_last(out_last), .tile_cnt(tile_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4*DW-1:0] pack_in(input int t, input int r);
      logic [4*DW-1:0] v;
      v = '0;
      for (int j = 0; j < 4; j++) v[j*DW +: DW] = DW'(tx[t][r*4+j]);
      return v;
   endfunction

   function automatic int rnd_elem();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic drive(input int first, input int n, input int row_i, input bit rnd);
      int t, r;
      if (row_i < n*4) begin
         t = first + row_i / 4;
         r = row_i % 4;
         in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_row   = pack_in(t, r);
         if (r == 0) mode_bypass = tbyp[t];
         else        mode_bypass = tbyp[t] ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
         in_valid    = 1'b0;
         in_row      = '0;
         mode_bypass = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   // Streams tiles tx[first..first+n-1]; entered and left at posedge+1, pipeline empty on entry
   task automatic run_tiles(input int first, input int n, input bit rnd);
      logic [4*OW-1:0] exp_q [$];
      logic [4*OW-1:0] e;
      int y;
      int row_i = 0;
      int occ = 0;
      int k_out = 0;
      int budget = 20000;
      bit fin, fout;
      for (int t = first; t < first + n; t++) begin
         for (int k = 0; k < 4; k++) begin
            e = '0;
            for (int j = 0; j < 4; j++) begin
               if (tbyp[t]) begin
                  y = tx[t][k*4+j];
               end else begin
                  y = 0;
                  for (int r = 0; r < 4; r++)
                     for (int c = 0; c < 4; c++)
                        y += mm[k][r] * tx[t][r*4+c] * mm[j][c];
               end
               e[j*OW +: OW] = OW'(y);
            end
            exp_q.push_back(e);
         end
      end
      drive(first, n, row_i, rnd);
      while (1) begin
         @(negedge clk);
         chk("in_ready", in_ready, occ < 2);
         chk("out_valid", out_valid, occ > 0);
         chk("tile_cnt_run", tile_cnt, CW'(tiles_total));
         fin  = in_valid && in_ready;
         fout = out_valid && out_ready;
         if (out_valid && exp_q.size() > 0) begin
            chk("out_row", out_row, exp_q[0]);
            chk("out_row_idx", out_row_idx, k_out[1:0]);
            chk("out_last", out_last, k_out == 3);
         end else if (!out_valid) begin
            chk("idle_outputs", {out_row, out_row_idx, out_last}, '0);
         end
         if (fin) begin
            if (row_i % 4 == 3) occ++;
            row_i++;
         end
         if (fout && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            if (k_out == 3) begin
               occ--;
               tiles_total++;
            end
            k_out = (k_out + 1) % 4;
         end
         if (row_i == n*4 && exp_q.size() == 0) break;
         budget--;
         if (budget == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL timeout: rows_in %0d rows_pending %0d", row_i, exp_q.size());
            break;
         end
         @(posedge clk); #1;
         drive(first, n, row_i, rnd);
      end
      @(posedge clk); #1;
      in_valid    = 1'b0;
      mode_bypass = 1'b0;
      out_ready   = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_row", out_row, '0);
      chk("rst_out_row_idx", out_row_idx, 2'd0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_tile_cnt", tile_cnt, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Sequential tile 1..16
      for (int i = 0; i < 16; i++) tx[0][i] = i + 1;
      tbyp[0] = 1'b0;
      run_tiles(0, 1, 1'b0);
      chk("tile_cnt_seq", tile_cnt, CW'(1));

      // Extremes
      for (int i = 0; i < 16; i++) begin
         tx[0][i] = 32767;
         tx[1][i] = -32768;
      end
      tbyp[0] = 1'b0;
      tbyp[1] = 1'b0;
      run_tiles(0, 2, 1'b0);
      chk("tile_cnt_ext", tile_cnt, CW'(3));

      // Bypass tile followed by a normal tile
      for (int i = 0; i < 16; i++) begin
         tx[0][i] = (i % 2 == 0) ? -(i + 1) : (i + 1);
         tx[1][i] = rnd_elem();
      end
      tbyp[0] = 1'b1;
      tbyp[1] = 1'b0;
      run_tiles(0, 2, 1'b0);
      chk("tile_cnt_byp", tile_cnt, CW'(5));

      // 100 random tiles with random backpressure
      for (int t = 0; t < 100; t++) begin
         tbyp[t] = 1'b0;
         for (int i = 0; i < 16; i++) tx[t][i] = rnd_elem();
      end
      run_tiles(0, 100, 1'b1);
      chk("tile_cnt_rand", tile_cnt, CW'(105));

      // Flush after two rows, with a row presented during the flush cycle
      for (int i = 0; i < 16; i++) tx[1][i] = rnd_elem();
      tbyp[1] = 1'b0;
      in_valid = 1'b1;
      in_row = pack_in(1, 0);
      @(negedge clk);
      chk("pre_flush_ready0", in_ready, 1'b1);
      @(posedge clk); #1;
      in_row = pack_in(1, 1);
      @(negedge clk);
      chk("pre_flush_ready1", in_ready, 1'b1);
      @(posedge clk); #1;
      flush = 1'b1;
      in_row = pack_in(1, 2);
      @(negedge clk);
      chk("flush_in_ready", in_ready, 1'b0);
      chk("flush_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) tx[0][i] = i + 1;
      tbyp[0] = 1'b0;
      run_tiles(0, 1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("post_flush_idle", out_valid, 1'b0);
      end
      chk("tile_cnt_flush", tile_cnt, CW'(106));

      // Reset pulse in the middle of egress at k=1
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         in_valid = 1'b1;
         in_row = pack_in(0, r);
         @(negedge clk);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_k0_valid", out_valid, 1'b1);
      chk("mid_k0_idx", out_row_idx, 2'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_k1_valid", out_valid, 1'b1);
      chk("mid_k1_idx", out_row_idx, 2'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_in_ready", in_ready, 1'b1);
      chk("arst_tile_cnt", tile_cnt, '0);
      chk("arst_out_row", {out_row, out_row_idx, out_last}, '0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tiles_total = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) tx[0][i] = rnd_elem();
      run_tiles(0, 1, 1'b0);
      chk("tile_cnt_after_rst", tile_cnt, CW'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pretu_stream.md
Name: pretu_stream

Overview:
- Streaming, pipelined successor to the combinational 4x4 PreTu input transform. Computes Y = Bt·X·B per 4x4 tile using the same row operator: y0=a-c, y1=b+c, y2=c-b, y3=b-d.
- Tiles enter one row per cycle and leave one row per cycle over valid/ready handshakes.
- Ping-pong tile banks give sustained throughput of one row per cycle.
- Optional per-tile bypass mode. Sits between the feature-map line buffer and the elementwise-multiply stage of the SFTM datapath.

Parameters:
- DW, 16, input element width (signed).
- CW, 16, width of the tile_cnt completed-tile counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of the partially written tile.
- mode_bypass  in  1  sampled with row 0 of each tile. 1 = pass X through sign-extended.
- in_valid  in  1  input row valid.
- in_ready  out  1  block can accept a row.
- in_row  in  4*DW  X[r][0..3]; element 0 in the LSBs, signed.
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accepts the row.
- out_row  out  4*(DW+2)  Y[k][0..3]; element 0 in the LSBs, signed.
- out_row_idx  out  2  k of the current output row.
- out_last  out  1  high with k==3.
- tile_cnt  out  CW  count of tiles fully emitted; wraps modulo 2^CW.

Behaviour:
- Reset (async, rst_n=0):
  - Both banks empty; wr_bank=rd_bank=0; write and read row counters = 0; tile_cnt=0.
  - out_valid=0, in_ready=1.
  - out_row=0, out_row_idx=0, out_last=0.
- Ingress:
  - A row transfers when in_valid & in_ready.
  - Each accepted row r is row-transformed on entry: R[r][0]=x0-x2, R[r][1]=x1+x2, R[r][2]=x2-x1, R[r][3]=x1-x3. Each result is DW+1 bits, sign-extended before the operation, with no overflow.
  - R[r] is stored in bank[wr_bank].
  - Bypass: R[r][j]=sign-extend(x_j).
  - The bypass flag is latched into the bank on row 0 and ignored on rows 1..3.
  - On acceptance of row 3: bank marked full on the next edge, wr_bank toggles, write counter returns to 0.
- in_ready = !full[wr_bank]. It is registered-state derived, with no combinational path from out_ready.
- Egress:
  - out_valid = full[rd_bank].
  - The column transform is combinational from bank registers, with k = read counter:
    - k=0: Y[0][j]=R0j-R2j
    - k=1: Y[1][j]=R1j+R2j
    - k=2: Y[2][j]=R2j-R1j
    - k=3: Y[3][j]=R1j-R3j
  - Results are DW+2 bits. Bypass: Y[k][j]=sign-extend(R[k][j]).
  - On out_valid & out_ready: the read counter increments.
  - At k=3: bank freed, rd_bank toggles, tile_cnt increments (all on the same edge).
  - out_row, out_row_idx and out_last are forced to 0 while out_valid=0.
- Latency: first output row is valid in the cycle after the edge that accepts input row 3 (1 cycle). Output is held stable while out_valid & !out_ready.
- Throughput: with out_ready=1 continuously, back-to-back tiles stream with in_ready never deasserting. 8 rows in flight max (two banks).
- Both banks full: in_ready=0. The bank freed at egress k=3 makes in_ready=1 on the following cycle.
- Simultaneous ingress and egress always target different banks, because a bank is written only while empty and read only while full.
- flush=1:
  - Clears the write counter and discards the partial rows in bank[wr_bank].
  - A row presented in the flush cycle is not accepted: in_ready is forced to 0 during flush.
  - Full banks and egress are unaffected.
- Reset mid-tile: all state is lost immediately; no rows are emitted.

Test Plan:
- Sequential tile X = 1..16 row-major, out_ready=1 → out rows [0,-16,0,0], [-4,34,2,-4], [0,8,0,0], [0,-16,0,0]. out_last on row 3; tile_cnt=1.
- All 32767 → rows [0,0,0,0], [0,131068,0,0], [0,0,0,0], [0,0,0,0]. All -32768 → row1 = [0,-131072,0,0], others 0. No wrap at the 18-bit extremes.
- 100 random tiles back-to-back, with out_ready random (50%) → every output matches a golden Bt·X·B model. Rows are held stable under stall. in_ready drops only when both banks are full; tile_cnt=100.
- Bypass: mode_bypass=1 on row 0 and 0 on rows 1..3 with X = -1,2,-3,4,... → output equals X sign-extended to 18 bits. The next tile with mode 0 is transformed normally.
- Flush after 2 rows, then a full tile of 1..16 → only one tile is emitted, equal to the sequential result; in_ready=0 in the flush cycle.
- rst_n pulsed low mid-egress at k=1 → out_valid=0 and in_ready=1 immediately; tile_cnt=0. A subsequent tile is processed correctly.
